acc_bias_relu: RTL and testbench



---
 rtl/cnn_pkg.sv | 16 +
 rtl/round_shift_sat.sv | 68 ++++++
 rtl/acc_bias_relu.sv | 87 ++++++++
 tb/tb_acc_bias_relu.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared widths and defaults for the CNN datapath stages.
// Also provides the helper that sizes an accumulator so that it cannot overflow internally.
package cnn_pkg;

    localparam int WDP_IN_DEF   = 17;
    localparam int WDP_BIAS_DEF = 13;
    localparam int WDP_DEF      = 9;
    localparam int ACC_NUM_DEF  = 4;
    localparam int SHIFT_DEF    = 2;

    // Widest operand, plus growth from summing acc_num terms, plus one bit for the bias add.
    function automatic int calc_wdp_acc(input int w_in, input int w_bias, input int acc_num);
        return ((w_in > w_bias) ? w_in : w_bias) + $clog2(acc_num) + 1;
    endfunction

endpackage

// File: rtl/round_shift_sat.sv
// Output conditioning in two register stages: round-half-up shift, then ReLU and saturation.
// Shared with the pooling stage.
module round_shift_sat
    import cnn_pkg::*;
#(
    parameter int WDP_ACC = 20,
    parameter int WDP     = WDP_DEF,
    parameter int SHIFT   = SHIFT_DEF,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_en,
    input  logic signed [WDP_ACC-1:0] in_data,
    output logic                      q_en,
    output logic signed [WDP-1:0]     q,
    output logic                      sat
);

    // One spare bit keeps the rounding constant from wrapping a full-scale input.
    localparam int WDP_R = WDP_ACC + 1;
    localparam logic signed [WDP_R-1:0] RND =
        (SHIFT > 0) ? WDP_R'(1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [WDP_R-1:0] MAX_V = WDP_R'(2 ** (WDP - 1) - 1);
    localparam logic signed [WDP_R-1:0] MIN_V = WDP_R'(-(2 ** (WDP - 1)));

    logic signed [WDP_R-1:0] rounded;
    logic signed [WDP_R-1:0] shifted;
    logic signed [WDP_R-1:0] r;
    logic                    v2;

    always_comb begin
        rounded = WDP_R'(in_data) + RND;
        shifted = rounded >>> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            r    <= '0;
            q_en <= 1'b0;
            q    <= '0;
            sat  <= 1'b0;
        end else begin
            v2   <= in_en;
            if (in_en) begin
                r <= shifted;
            end
            q_en <= v2;
            sat  <= 1'b0;
            // q keeps its previous value whenever no result is leaving the stage.
            if (v2) begin
                if (RELU_EN && (r < 0)) begin
                    q <= '0;
                end else if (r > MAX_V) begin
                    q   <= MAX_V[WDP-1:0];
                    sat <= 1'b1;
                end else if (!RELU_EN && (r < MIN_V)) begin
                    q   <= MIN_V[WDP-1:0];
                    sat <= 1'b1;
                end else begin
                    q <= r[WDP-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/acc_bias_relu.sv
// Post-MAC output stage: sums ACC_NUM partial sums per pixel and adds the channel bias.
// It then rescales, optionally applies ReLU and saturates the result to the feature format.
module acc_bias_relu
    import cnn_pkg::*;
#(
    parameter int WDP_IN   = WDP_IN_DEF,
    parameter int WDP_BIAS = WDP_BIAS_DEF,
    parameter int WDP      = WDP_DEF,
    parameter int ACC_NUM  = ACC_NUM_DEF,
    parameter int SHIFT    = SHIFT_DEF,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       d_en,
    input  logic signed [WDP_IN-1:0]   d,
    input  logic signed [WDP_BIAS-1:0] bias,
    output logic                       q_en,
    output logic signed [WDP-1:0]      q,
    output logic                       sat
);

    localparam int WDP_ACC = calc_wdp_acc(WDP_IN, WDP_BIAS, ACC_NUM);
    localparam int CNT_W   = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_NUM - 1);

    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_eff;
    logic [CNT_W-1:0]          cnt_next;
    logic signed [WDP_ACC-1:0] acc;
    logic signed [WDP_ACC-1:0] acc_base;
    logic signed [WDP_ACC-1:0] beat_sum;
    logic signed [WDP_ACC-1:0] s1;
    logic                      v1;
    logic                      is_last;

    // A clr arriving with a beat makes that beat the first of a fresh group.
    always_comb begin
        cnt_eff  = clr ? '0 : cnt;
        cnt_next = cnt_eff + 1'b1;
        acc_base = (cnt_eff == '0) ? '0 : acc;
        beat_sum = acc_base + WDP_ACC'(d);
        is_last  = (cnt_eff == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            s1  <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= 1'b0;
            if (d_en) begin
                if (is_last) begin
                    s1  <= beat_sum + WDP_ACC'(bias);
                    v1  <= 1'b1;
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    acc <= beat_sum;
                    cnt <= cnt_next;
                end
            end else if (clr) begin
                cnt <= '0;
                acc <= '0;
            end
        end
    end

    round_shift_sat #(
        .WDP_ACC (WDP_ACC),
        .WDP     (WDP),
        .SHIFT   (SHIFT),
        .RELU_EN (RELU_EN)
    ) u_round_shift_sat (
        .clk     (clk),
        .rst     (rst),
        .in_en   (v1),
        .in_data (s1),
        .q_en    (q_en),
        .q       (q),
        .sat     (sat)
    );

endmodule

// File: tb/tb_acc_bias_relu.sv
// Bench for acc_bias_relu: three configurations share one stimulus stream.
// Every output cycle is compared against an arithmetic model, and literal results pin down the model.
module tb_acc_bias_relu;

    typedef struct {
        int due;
        int q;
        bit sat;
    } exp_t;

    logic               clk  = 1'b0;
    logic               rst  = 1'b1;
    logic               clr  = 1'b0;
    logic               d_en = 1'b0;
    logic signed [16:0] d    = '0;
    logic signed [12:0] bias = '0;

    logic              q_en_a, q_en_b, q_en_c;
    logic signed [8:0] q_a, q_b, q_c;
    logic              sat_a, sat_b, sat_c;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int cfg_acc[3]   = '{4, 4, 1};
    int cfg_shift[3] = '{2, 2, 0};
    bit cfg_relu[3]  = '{1'b1, 1'b0, 1'b1};

    longint model_sum[3];
    int     model_cnt[3];
    int     pulses[3];
    int     last_pulse[3];
    int     prev_pulse[3];
    bit     last_sat[3];
    exp_t   exp_a[$];
    exp_t   exp_b[$];
    exp_t   exp_c[$];

    always #5 clk = ~clk;

    acc_bias_relu dut_a (
        .clk(clk), .rst(rst), .clr(clr), .d_en(d_en), .d(d), .bias(bias),
        .q_en(q_en_a), .q(q_a), .sat(sat_a)
    );

    acc_bias_relu #(.RELU_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .d_en(d_en), .d(d), .bias(bias),
        .q_en(q_en_b), .q(q_b), .sat(sat_b)
    );

    acc_bias_relu #(.ACC_NUM(1), .SHIFT(0)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .d_en(d_en), .d(d), .bias(bias),
        .q_en(q_en_c), .q(q_c), .sat(sat_c)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Round-half-up shift, then ReLU / clamp to the 9-bit signed range.
    function automatic exp_t model_out(input longint sum, input int shift, input bit relu);
        exp_t   e;
        longint r;
        r = (sum + ((shift > 0) ? (longint'(1) << (shift - 1)) : 64'sd0)) >>> shift;
        e.due = 0;
        e.sat = 1'b0;
        if (relu && r < 0)              e.q = 0;
        else if (r > 255)               begin e.q = 255;  e.sat = 1'b1; end
        else if (!relu && r < -256)     begin e.q = -256; e.sat = 1'b1; end
        else                            e.q = int'(r);
        return e;
    endfunction

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0:       exp_a.push_back(e);
            1:       exp_b.push_back(e);
            default: exp_c.push_back(e);
        endcase
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    model_sum[i] = 0;
                    model_cnt[i] = 0;
                end
                exp_a.delete();
                exp_b.delete();
                exp_c.delete();
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (clr) begin
                        model_sum[i] = 0;
                        model_cnt[i] = 0;
                    end
                    if (d_en) begin
                        model_sum[i] += d;
                        model_cnt[i]++;
                        if (model_cnt[i] == cfg_acc[i]) begin
                            e = model_out(model_sum[i] + bias, cfg_shift[i], cfg_relu[i]);
                            e.due = cyc + 2;
                            push_exp(i, e);
                            model_sum[i] = 0;
                            model_cnt[i] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic compare_one(input int i, input logic qen, input int qv, input logic satv);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (i)
            0: if (exp_a.size() > 0 && exp_a[0].due == cyc) begin e = exp_a.pop_front(); have = 1'b1; end
            1: if (exp_b.size() > 0 && exp_b[0].due == cyc) begin e = exp_b.pop_front(); have = 1'b1; end
            default: if (exp_c.size() > 0 && exp_c[0].due == cyc) begin e = exp_c.pop_front(); have = 1'b1; end
        endcase
        if (have) begin
            checkOutput($sformatf("q_en[%0d]@%0d", i, cyc), longint'(qen), 1);
            checkOutput($sformatf("q[%0d]@%0d", i, cyc), qv, e.q);
            checkOutput($sformatf("sat[%0d]@%0d", i, cyc), longint'(satv), longint'(e.sat));
        end else begin
            checkOutput($sformatf("q_en_idle[%0d]@%0d", i, cyc), longint'(qen), 0);
            checkOutput($sformatf("sat_idle[%0d]@%0d", i, cyc), longint'(satv), 0);
        end
        if (qen === 1'b1) begin
            pulses[i]++;
            prev_pulse[i] = last_pulse[i];
            last_pulse[i] = cyc;
            last_sat[i]   = satv;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                compare_one(0, q_en_a, int'(q_a), sat_a);
                compare_one(1, q_en_b, int'(q_b), sat_b);
                compare_one(2, q_en_c, int'(q_c), sat_c);
            end
        end
    end

    task automatic applyStimulus(input logic den, input int dval, input int bval, input logic clrv);
        @(negedge clk);
        d_en = den;
        d    = 17'(dval);
        bias = 13'(bval);
        clr  = clrv;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst  = 1'b1;
        d_en = 1'b0;
        clr  = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    initial begin
        int t_last;
        int p0;
        for (int i = 0; i < 3; i++) begin
            pulses[i] = 0;
            last_pulse[i] = 0;
            prev_pulse[i] = 0;
            last_sat[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset_q", q_a, 0);
        checkOutput("reset_q_en", longint'(q_en_a), 0);
        checkOutput("reset_sat", longint'(sat_a), 0);
        rst = 1'b0;

        p0 = pulses[0];
        applyStimulus(1'b1, 10, 0, 1'b0);
        applyStimulus(1'b1, 20, 0, 1'b0);
        applyStimulus(1'b1, 30, 0, 1'b0);
        applyStimulus(1'b1, 40, 4, 1'b0);
        t_last = cyc;
        idle(6);
        checkOutput("t1_q", q_a, 26);
        checkOutput("t1_latency", last_pulse[0] - t_last, 3);
        checkOutput("t1_pulses", pulses[0] - p0, 1);

        applyStimulus(1'b1, -100, 0, 1'b0);
        applyStimulus(1'b1, -1, 0, 1'b0);
        applyStimulus(1'b1, 0, 0, 1'b0);
        applyStimulus(1'b1, 0, 0, 1'b0);
        idle(6);
        checkOutput("t2_relu_q", q_a, 0);
        checkOutput("t2_norelu_q", q_b, -25);

        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 65535, (k == 3) ? 4095 : 0, 1'b0);
        idle(6);
        checkOutput("t3_pos_q", q_a, 255);
        checkOutput("t3_pos_sat", longint'(last_sat[0]), 1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, -65536, (k == 3) ? -4096 : 0, 1'b0);
        idle(6);
        checkOutput("t3_neg_q", q_b, -256);
        checkOutput("t3_neg_sat", longint'(last_sat[1]), 1);
        checkOutput("t3_neg_relu_q", q_a, 0);

        p0 = pulses[0];
        applyStimulus(1'b1, 10, 0, 1'b0);
        idle(3);
        applyStimulus(1'b1, 20, 0, 1'b0);
        idle(3);
        applyStimulus(1'b1, 30, 0, 1'b0);
        idle(3);
        applyStimulus(1'b1, 40, 4, 1'b0);
        t_last = cyc;
        idle(6);
        checkOutput("t4_q", q_a, 26);
        checkOutput("t4_latency", last_pulse[0] - t_last, 3);
        checkOutput("t4_pulses", pulses[0] - p0, 1);

        p0 = pulses[0];
        applyStimulus(1'b1, 10, 0, 1'b0);
        applyStimulus(1'b1, 20, 0, 1'b0);
        applyStimulus(1'b1, 30, 0, 1'b0);
        applyStimulus(1'b1, 40, 4, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1, 0, 1'b0);
        idle(6);
        checkOutput("t5_q", q_a, 1);
        checkOutput("t5_spacing", last_pulse[0] - prev_pulse[0], 4);
        checkOutput("t5_pulses", pulses[0] - p0, 2);

        p0 = pulses[0];
        applyStimulus(1'b1, 50, 0, 1'b0);
        applyStimulus(1'b1, 50, 0, 1'b0);
        pulse_reset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1, 0, 1'b0);
        idle(6);
        checkOutput("t6_rst_q", q_a, 1);
        checkOutput("t6_rst_pulses", pulses[0] - p0, 1);

        p0 = pulses[0];
        applyStimulus(1'b1, 50, 0, 1'b0);
        applyStimulus(1'b1, 50, 0, 1'b0);
        applyStimulus(1'b1, 1, 0, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1, 0, 1'b0);
        idle(6);
        checkOutput("t7_clr_q", q_a, 1);
        checkOutput("t7_clr_pulses", pulses[0] - p0, 1);

        p0 = pulses[2];
        applyStimulus(1'b1, 7, -3, 1'b0);
        t_last = cyc;
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, 7, -3, 1'b0);
        idle(6);
        checkOutput("t8_acc1_q", q_c, 4);
        checkOutput("t8_acc1_pulses", pulses[2] - p0, 8);
        checkOutput("t8_acc1_first", last_pulse[2] - t_last, 3 + 7);

        checkOutput("pending_a", exp_a.size(), 0);
        checkOutput("pending_b", exp_b.size(), 0);
        checkOutput("pending_c", exp_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
